// File: rtl/bimux_nx1_sync_pkg.sv
// -----------------------------------------------------------------------------
// bimux_nx1_sync_pkg
//   Shared encodings for the bidirectional N:1 channel mux.
//   - MODE_*  : request / cur_mode encodings
//   - state_e : controller states
//   - mode_of_state() : maps a controller state to the cur_mode encoding
// -----------------------------------------------------------------------------
package bimux_nx1_sync_pkg;

  localparam logic [1:0] MODE_REL = 2'b00;
  localparam logic [1:0] MODE_FWD = 2'b01;
  localparam logic [1:0] MODE_REV = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FWD  = 2'b01,
    ST_REV  = 2'b10,
    ST_TURN = 2'b11
  } state_e;

  // IDLE and TURN both report the released encoding.
  function automatic logic [1:0] mode_of_state(input state_e st);
    case (st)
      ST_FWD:  return MODE_FWD;
      ST_REV:  return MODE_REV;
      default: return MODE_REL;
    endcase
  endfunction

endpackage

// File: rtl/bimux_nx1_sync_if.sv
// -----------------------------------------------------------------------------
// bimux_nx1_sync_if
//   Request handshake plus channel / single-port bus bundle.
//   master : requester and bus environment (drives requests, ch_in, port_in)
//   slave  : the mux (drives ready, enables, data registers, status)
// -----------------------------------------------------------------------------
interface bimux_nx1_sync_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3
);
  logic                      req_valid;
  logic                      req_ready;
  logic [1:0]                req_mode;
  logic [SEL_W-1:0]          req_sel;
  logic [CHANNELS*WIDTH-1:0] ch_in;
  logic [CHANNELS*WIDTH-1:0] ch_out;
  logic [CHANNELS-1:0]       ch_oe;
  logic [WIDTH-1:0]          port_in;
  logic [WIDTH-1:0]          port_out;
  logic                      port_oe;
  logic [1:0]                cur_mode;
  logic                      busy;
  logic                      req_err;

  modport master (
    output req_valid, req_mode, req_sel, ch_in, port_in,
    input  req_ready, ch_out, ch_oe, port_out, port_oe, cur_mode, busy, req_err
  );

  modport slave (
    input  req_valid, req_mode, req_sel, ch_in, port_in,
    output req_ready, ch_out, ch_oe, port_out, port_oe, cur_mode, busy, req_err
  );
endinterface

// File: rtl/bimux_nx1_sync_turn_timer.sv
// -----------------------------------------------------------------------------
// bimux_turn_timer
//   Loadable down-counter timing the bus-turnaround interval.
//   Ports: clk, rst (sync, active-high), load_i / load_val_i (load count),
//          dec_i (count down, saturating at zero), done_o (count is zero).
// -----------------------------------------------------------------------------
module bimux_turn_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority, otherwise saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/bimux_nx1_sync.sv
// -----------------------------------------------------------------------------
// bimux_nx1_sync
//   Clocked bidirectional N:1 channel mux.
//   FWD: ch_in[sel] is registered onto port_out, port_oe=1.
//   REV: port_in is registered into holding register ch_out[sel], ch_oe=one-hot.
//   Any change of driver that is not from a released bus passes through TURN,
//   TURN_CYCLES cycles with every enable low, so external tristates never fight.
//   Ports: clk, rst (sync, active-high), bus (bimux_nx1_sync_if.slave).
// -----------------------------------------------------------------------------
module bimux_nx1_sync
  import bimux_nx1_sync_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int CHANNELS    = 8,
  parameter int SEL_W       = 3,
  parameter int TURN_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  bimux_nx1_sync_if.slave        bus
);

  localparam int               CNT_W     = $clog2(TURN_CYCLES + 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [SEL_W:0]   CH_LIM    = (SEL_W + 1)'(CHANNELS);

  state_e                          state_q, state_d;
  state_e                          pend_state_q, pend_state_d;
  logic [SEL_W-1:0]                sel_q, sel_d;
  logic [SEL_W-1:0]                pend_sel_q, pend_sel_d;
  logic [WIDTH-1:0]                port_out_q, port_out_d;
  logic [CHANNELS-1:0]             ch_oe_q, ch_oe_d;
  logic                            port_oe_q, port_oe_d;
  logic [1:0]                      cur_mode_q, cur_mode_d;
  logic                            busy_q, busy_d;
  logic                            req_err_q, req_err_d;
  logic                            req_ready_q, req_ready_d;

  logic                            accept_s;
  logic                            sel_bad_s;
  logic                            turn_done_s;
  logic                            turn_load_s;
  logic                            turn_dec_s;
  logic [CHANNELS-1:0][WIDTH-1:0]  ch_in_s;
  logic [CHANNELS-1:0][WIDTH-1:0]  hold_s;

  assign ch_in_s   = bus.ch_in;
  assign accept_s  = bus.req_valid & req_ready_q;
  assign sel_bad_s = ({1'b0, bus.req_sel} >= CH_LIM);

  // Next-state, select and pending-request logic.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    pend_state_d = pend_state_q;
    pend_sel_d   = pend_sel_q;
    req_err_d    = 1'b0;
    if (accept_s) begin
      if (sel_bad_s) begin
        state_d   = ST_IDLE;
        req_err_d = 1'b1;
      end else begin
        case (bus.req_mode)
          MODE_REL: begin
            state_d = ST_IDLE;
          end
          MODE_FWD: begin
            // From REV the channel driver must release before the port drives.
            if (state_q == ST_REV) begin
              state_d      = ST_TURN;
              pend_state_d = ST_FWD;
              pend_sel_d   = bus.req_sel;
            end else begin
              state_d = ST_FWD;
              sel_d   = bus.req_sel;
            end
          end
          MODE_REV: begin
            // Changing which external driver is active needs a turnaround.
            if ((state_q == ST_FWD) ||
                ((state_q == ST_REV) && (bus.req_sel != sel_q))) begin
              state_d      = ST_TURN;
              pend_state_d = ST_REV;
              pend_sel_d   = bus.req_sel;
            end else begin
              state_d = ST_REV;
              sel_d   = bus.req_sel;
            end
          end
          default: begin
            state_d   = ST_IDLE;
            req_err_d = 1'b1;
          end
        endcase
      end
    end else if (state_q == ST_TURN) begin
      if (turn_done_s) begin
        state_d = pend_state_q;
        sel_d   = pend_sel_q;
      end else begin
        state_d = ST_TURN;
      end
    end else begin
      state_d = state_q;
    end
  end

  assign turn_load_s = (state_d == ST_TURN) && (state_q != ST_TURN);
  assign turn_dec_s  = (state_q == ST_TURN);

  // Registered outputs are decoded from the next state so they change with it.
  always_comb begin
    port_oe_d   = (state_d == ST_FWD);
    busy_d      = (state_d == ST_TURN);
    req_ready_d = (state_d != ST_TURN);
    cur_mode_d  = mode_of_state(state_d);
    if (state_d == ST_REV) begin
      ch_oe_d = {{(CHANNELS-1){1'b0}}, 1'b1} << sel_d;
    end else begin
      ch_oe_d = {CHANNELS{1'b0}};
    end
    if (state_d == ST_FWD) begin
      port_out_d = ch_in_s[sel_d];
    end else begin
      port_out_d = port_out_q;
    end
  end

  // Controller and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_state_q <= ST_IDLE;
      sel_q        <= {SEL_W{1'b0}};
      pend_sel_q   <= {SEL_W{1'b0}};
      port_out_q   <= {WIDTH{1'b0}};
      ch_oe_q      <= {CHANNELS{1'b0}};
      port_oe_q    <= 1'b0;
      cur_mode_q   <= MODE_REL;
      busy_q       <= 1'b0;
      req_err_q    <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      pend_state_q <= pend_state_d;
      sel_q        <= sel_d;
      pend_sel_q   <= pend_sel_d;
      port_out_q   <= port_out_d;
      ch_oe_q      <= ch_oe_d;
      port_oe_q    <= port_oe_d;
      cur_mode_q   <= cur_mode_d;
      busy_q       <= busy_d;
      req_err_q    <= req_err_d;
      req_ready_q  <= req_ready_d;
    end
  end

  bimux_turn_timer #(
    .CNT_W (CNT_W)
  ) u_turn_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (turn_load_s),
    .load_val_i (TURN_LOAD),
    .dec_i      (turn_dec_s),
    .done_o     (turn_done_s)
  );

  // Per-channel holding registers; only the selected one loads, and only in REV.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_hold
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;

    // Capture port_in while this channel is the active reverse target.
    always_comb begin
      if ((state_q == ST_REV) && (sel_q == SEL_W'(k))) begin
        hold_d = bus.port_in;
      end else begin
        hold_d = hold_q;
      end
    end

    // Holding register.
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= {WIDTH{1'b0}};
      end else begin
        hold_q <= hold_d;
      end
    end

    assign hold_s[k] = hold_q;
  end

  assign bus.ch_out    = hold_s;
  assign bus.ch_oe     = ch_oe_q;
  assign bus.port_out  = port_out_q;
  assign bus.port_oe   = port_oe_q;
  assign bus.cur_mode  = cur_mode_q;
  assign bus.busy      = busy_q;
  assign bus.req_err   = req_err_q;
  assign bus.req_ready = req_ready_q;

endmodule
